// File: rtl/muldiv_ctrl_if.sv
// ---------------------------------------------------------------------------
// muldiv_ctrl_if
// Handshake and data bundle between the EX stage and the multicycle HI/LO
// unit (muldiv_ctrl).
//
// Signals:
//   start_i     EX -> unit   request a multicycle operation (held until ready_o)
//   op_i[2:0]   EX -> unit   0 MULT,1 MULTU,2 MADD,3 MADDU,4 MSUB,5 MSUBU,6 DIV,7 DIVU
//   opdata1_i   EX -> unit   rs operand / dividend
//   opdata2_i   EX -> unit   rt operand / divisor
//   hi_i, lo_i  EX -> unit   forwarded HI/LO, base for MADD/MSUB
//   annul_i     EX -> unit   pipeline flush
//   result_o    unit -> EX   {HI,LO}; {remainder, quotient} for divides
//   ready_o     unit -> EX   result_o valid
//   stallreq_o  unit -> EX   stall request
//   busy_o      unit -> EX   unit is not idle
//
// Modports:
//   master  the EX side that issues requests
//   slave   the multiply/divide unit
// ---------------------------------------------------------------------------
interface muldiv_ctrl_if;
   logic        start_i;
   logic [2:0]  op_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic [31:0] hi_i;
   logic [31:0] lo_i;
   logic        annul_i;
   logic [63:0] result_o;
   logic        ready_o;
   logic        stallreq_o;
   logic        busy_o;

   modport master (
      output start_i, op_i, opdata1_i, opdata2_i, hi_i, lo_i, annul_i,
      input  result_o, ready_o, stallreq_o, busy_o
   );

   modport slave (
      input  start_i, op_i, opdata1_i, opdata2_i, hi_i, lo_i, annul_i,
      output result_o, ready_o, stallreq_o, busy_o
   );
endinterface

// File: rtl/muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// muldiv_ctrl
// Multicycle multiply / multiply-accumulate / divide unit that produces a
// 64-bit {HI,LO} result for the EX stage.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   muldiv_ctrl_if.slave (start/op/operands/hi/lo/annul in,
//         result/ready/stallreq/busy out)
//
// Flow:
//   IDLE -> MUL -> DONE           MULT/MULTU        (ready after 2 cycles)
//   IDLE -> MUL -> ACC -> DONE    MADD*/MSUB*       (ready after 3 cycles)
//   IDLE -> DIV (33 cycles) -> DONE   DIV/DIVU      (ready after 34 cycles)
//   IDLE -> DONE                  divide by zero    (ready after 1 cycle)
//   DONE holds the result while start_i stays high.
//   annul_i returns to IDLE from any state; dropping start_i mid-operation
//   abandons the operation.
// ---------------------------------------------------------------------------
module muldiv_ctrl (
   input  logic            clk,
   input  logic            rst,
   muldiv_ctrl_if.slave    bus
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MUL,
      ST_ACC,
      ST_DIV,
      ST_DONE
   } state_t;

   // op_i[2:1] groups the opcodes into kinds; op_i[0]=0 marks the signed form
   localparam logic [1:0] KIND_MUL  = 2'd0;
   localparam logic [1:0] KIND_MADD = 2'd1;
   localparam logic [1:0] KIND_MSUB = 2'd2;
   localparam logic [1:0] KIND_DIV  = 2'd3;

   localparam logic [5:0] DIV_LAST = 6'd32;

   state_t      state_q;
   state_t      state_d;

   logic [1:0]  kind_q;
   logic [63:0] product_q;
   logic [31:0] divisor_q;
   logic [31:0] rem_q;
   logic [31:0] quo_q;
   logic [5:0]  cnt_q;
   logic        neg_quo_q;
   logic        neg_rem_q;
   logic [63:0] result_q;

   logic        signed_op;
   logic [1:0]  in_kind;
   logic        a_neg;
   logic        b_neg;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [63:0] prod_mag;
   logic        prod_neg;
   logic [63:0] prod_in;
   logic        div_by_zero;
   logic        advance;

   logic [32:0] div_partial;
   logic        div_fits;
   logic [31:0] div_diff;
   logic [31:0] quo_fixed;
   logic [31:0] rem_fixed;
   logic [63:0] acc_base;

   // Operand preparation: signed ops work on magnitudes so one unsigned
   // multiplier and one unsigned divider serve both flavours. The sign is
   // reapplied to the product here, and to the quotient/remainder at the end
   // of the divide. The magnitude of 0x80000000 is still 0x80000000 when
   // read as unsigned, so the most negative value needs no special case.
   always_comb begin
      signed_op   = ~bus.op_i[0];
      in_kind     = bus.op_i[2:1];
      a_neg       = signed_op & bus.opdata1_i[31];
      b_neg       = signed_op & bus.opdata2_i[31];
      a_mag       = a_neg ? (32'd0 - bus.opdata1_i) : bus.opdata1_i;
      b_mag       = b_neg ? (32'd0 - bus.opdata2_i) : bus.opdata2_i;
      prod_mag    = {32'd0, a_mag} * {32'd0, b_mag};
      prod_neg    = a_neg ^ b_neg;
      prod_in     = prod_neg ? (64'd0 - prod_mag) : prod_mag;
      div_by_zero = (bus.opdata2_i == 32'd0);
      advance     = bus.start_i & ~bus.annul_i;
   end

   // One restoring-divide step: shift the next dividend bit into the partial
   // remainder and subtract the divisor when it fits. The dividend is kept in
   // quo_q and shifted out as quotient bits are shifted in. Whenever the
   // subtraction is taken the true difference is below the divisor, so the
   // low 32 bits of the difference are exact.
   always_comb begin
      div_partial = {rem_q, quo_q[31]};
      div_fits    = (div_partial >= {1'b0, divisor_q});
      div_diff    = div_partial[31:0] - divisor_q;
      quo_fixed   = neg_quo_q ? (32'd0 - quo_q) : quo_q;
      rem_fixed   = neg_rem_q ? (32'd0 - rem_q) : rem_q;
      acc_base    = {bus.hi_i, bus.lo_i};
   end

   // State register. Reset lands in IDLE, which also drops ready/busy at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic. annul_i wins over everything; otherwise losing
   // start_i while working abandons the operation, and the DONE state
   // waits for EX to drop start_i before a new request can be accepted.
   always_comb begin
      state_d = state_q;
      if (bus.annul_i) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.start_i) begin
                  if (in_kind != KIND_DIV) begin
                     state_d = ST_MUL;
                  end else if (div_by_zero) begin
                     state_d = ST_DONE;
                  end else begin
                     state_d = ST_DIV;
                  end
               end
            end
            ST_MUL: begin
               if (!bus.start_i) begin
                  state_d = ST_IDLE;
               end else if (kind_q == KIND_MUL) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_ACC;
               end
            end
            ST_ACC: begin
               state_d = bus.start_i ? ST_DONE : ST_IDLE;
            end
            ST_DIV: begin
               if (!bus.start_i) begin
                  state_d = ST_IDLE;
               end else if (cnt_q == DIV_LAST) begin
                  state_d = ST_DONE;
               end
            end
            ST_DONE: begin
               if (!bus.start_i) begin
                  state_d = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Datapath. Operands, signs and the product are captured only when a
   // request is accepted in IDLE, so later changes on the operand inputs do
   // not disturb an operation in flight. result_q is written only on the
   // step that enters DONE; annul and abort leave it untouched.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         kind_q    <= KIND_MUL;
         product_q <= 64'd0;
         divisor_q <= 32'd0;
         rem_q     <= 32'd0;
         quo_q     <= 32'd0;
         cnt_q     <= 6'd0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         result_q  <= 64'd0;
      end else if (advance) begin
         case (state_q)
            ST_IDLE: begin
               kind_q    <= in_kind;
               product_q <= prod_in;
               divisor_q <= b_mag;
               quo_q     <= a_mag;
               rem_q     <= 32'd0;
               cnt_q     <= 6'd0;
               neg_quo_q <= prod_neg;
               neg_rem_q <= a_neg;
               if ((in_kind == KIND_DIV) && div_by_zero) begin
                  result_q <= 64'd0;
               end
            end
            ST_MUL: begin
               if (kind_q == KIND_MUL) begin
                  result_q <= product_q;
               end
            end
            ST_ACC: begin
               if (kind_q == KIND_MSUB) begin
                  result_q <= acc_base - product_q;
               end else begin
                  result_q <= acc_base + product_q;
               end
            end
            ST_DIV: begin
               if (cnt_q == DIV_LAST) begin
                  result_q <= {rem_fixed, quo_fixed};
               end else begin
                  rem_q <= div_fits ? div_diff : div_partial[31:0];
                  quo_q <= {quo_q[30:0], div_fits};
                  cnt_q <= cnt_q + 6'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Status outputs decode straight from the state so they follow reset
   // and annul without an extra cycle.
   always_comb begin
      bus.result_o   = result_q;
      bus.ready_o    = (state_q == ST_DONE);
      bus.busy_o     = (state_q != ST_IDLE);
      bus.stallreq_o = bus.start_i & ~bus.ready_o & ~bus.annul_i;
   end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// tb_muldiv_ctrl
// Directed self-checking bench for muldiv_ctrl: every opcode with hand
// computed results and latencies, DONE hold, annul, abort, async reset and
// divide by zero.
// ---------------------------------------------------------------------------
module tb_muldiv_ctrl;

   logic clk;
   logic rst;
   int   errors;
   int   checks;

   muldiv_ctrl_if bus ();

   muldiv_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one cycle and land 1 ns after the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Single comparison point
   task automatic check_output(input string tag, input logic [63:0] obs,
                               input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Issue one operation, measure latency to ready_o, check result, check
   // DONE hold, then release start and check the return to IDLE. Operand
   // inputs are scrambled after acceptance to show they are not re-sampled.
   task automatic apply_stimulus(input string tag, input logic [2:0] op,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] hi, input logic [31:0] lo,
                                 input int exp_lat, input logic [63:0] exp_res);
      int cyc;
      bus.op_i      = op;
      bus.opdata1_i = a;
      bus.opdata2_i = b;
      bus.hi_i      = hi;
      bus.lo_i      = lo;
      bus.start_i   = 1'b1;
      #1;
      check_output({tag, "_stall0"}, {63'd0, bus.stallreq_o}, 64'd1);
      check_output({tag, "_ready0"}, {63'd0, bus.ready_o}, 64'd0);
      cyc = 0;
      while (bus.ready_o !== 1'b1 && cyc < 100) begin
         tick();
         cyc++;
         if (cyc == 1) begin
            bus.opdata1_i = ~a;
            bus.opdata2_i = b ^ 32'h0000_0F0F;
            bus.op_i      = ~op;
            #1;
            if (bus.ready_o !== 1'b1) begin
               check_output({tag, "_stall1"}, {63'd0, bus.stallreq_o}, 64'd1);
            end
         end
      end
      check_output({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
      check_output({tag, "_res"}, bus.result_o, exp_res);
      check_output({tag, "_stall_rdy"}, {63'd0, bus.stallreq_o}, 64'd0);
      tick();
      check_output({tag, "_hold_rdy"}, {63'd0, bus.ready_o}, 64'd1);
      check_output({tag, "_hold_res"}, bus.result_o, exp_res);
      bus.start_i = 1'b0;
      tick();
      check_output({tag, "_idle_busy"}, {63'd0, bus.busy_o}, 64'd0);
      check_output({tag, "_idle_rdy"}, {63'd0, bus.ready_o}, 64'd0);
   endtask

   initial begin
      int  cyc;
      logic saw_ready;
      errors        = 0;
      checks        = 0;
      rst           = 1'b1;
      bus.start_i   = 1'b0;
      bus.op_i      = 3'd0;
      bus.opdata1_i = 32'd0;
      bus.opdata2_i = 32'd0;
      bus.hi_i      = 32'd0;
      bus.lo_i      = 32'd0;
      bus.annul_i   = 1'b0;
      $display("[TB] start");

      #3;
      check_output("rst_ready", {63'd0, bus.ready_o}, 64'd0);
      check_output("rst_busy", {63'd0, bus.busy_o}, 64'd0);
      check_output("rst_result", bus.result_o, 64'd0);
      check_output("rst_stall", {63'd0, bus.stallreq_o}, 64'd0);
      tick();
      rst = 1'b0;
      tick();

      apply_stimulus("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'h0000_0005, 32'd0, 32'd0,
                     2, 64'hFFFF_FFFF_FFFF_FFF1);
      apply_stimulus("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0,
                     2, 64'hFFFF_FFFE_0000_0001);
      apply_stimulus("mult_minint", 3'd0, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0,
                     2, 64'h4000_0000_0000_0000);
      apply_stimulus("maddu", 3'd3, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0000,
                     32'h0000_0001, 3, 64'h0000_0001_FFFF_FFFF);
      apply_stimulus("madd", 3'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                     32'hFFFF_FFFF, 3, 64'h0000_0000_0000_0005);
      apply_stimulus("msub", 3'd4, 32'h0000_0003, 32'hFFFF_FFFC, 32'h0000_0000,
                     32'h0000_000A, 3, 64'h0000_0000_0000_0016);
      apply_stimulus("msubu", 3'd5, 32'h0000_0002, 32'h0000_0003, 32'h0000_0001,
                     32'h0000_0000, 3, 64'h0000_0000_FFFF_FFFA);
      apply_stimulus("div_neg", 3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'd0, 32'd0,
                     34, 64'hFFFF_FFFF_FFFF_FFFD);
      apply_stimulus("div_negdiv", 3'd6, 32'h0000_0007, 32'hFFFF_FFFE, 32'd0, 32'd0,
                     34, 64'h0000_0001_FFFF_FFFD);
      apply_stimulus("divu", 3'd7, 32'h8000_0000, 32'h0000_0003, 32'd0, 32'd0,
                     34, 64'h0000_0002_2AAA_AAAA);

      // Annul a divide at cycle 10
      bus.op_i      = 3'd6;
      bus.opdata1_i = 32'd100;
      bus.opdata2_i = 32'd7;
      bus.start_i   = 1'b1;
      saw_ready     = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus.ready_o === 1'b1) saw_ready = 1'b1;
      end
      check_output("annul_busy_c10", {63'd0, bus.busy_o}, 64'd1);
      bus.annul_i = 1'b1;
      #1;
      check_output("annul_stall", {63'd0, bus.stallreq_o}, 64'd0);
      tick();
      bus.annul_i = 1'b0;
      bus.start_i = 1'b0;
      check_output("annul_idle", {63'd0, bus.busy_o}, 64'd0);
      check_output("annul_result", bus.result_o, 64'h0000_0002_2AAA_AAAA);
      for (int i = 0; i < 40; i++) begin
         tick();
         if (bus.ready_o === 1'b1) saw_ready = 1'b1;
      end
      check_output("annul_no_ready", {63'd0, saw_ready}, 64'd0);
      apply_stimulus("mult_after_annul", 3'd0, 32'd2, 32'd3, 32'd0, 32'd0,
                     2, 64'd6);

      // Abort a MADD by dropping start in MUL
      bus.op_i      = 3'd2;
      bus.opdata1_i = 32'd9;
      bus.opdata2_i = 32'd9;
      bus.start_i   = 1'b1;
      tick();
      bus.start_i = 1'b0;
      tick();
      check_output("abort_busy", {63'd0, bus.busy_o}, 64'd0);
      check_output("abort_ready", {63'd0, bus.ready_o}, 64'd0);
      check_output("abort_result", bus.result_o, 64'd6);

      // Asynchronous reset in DIV cycle 20
      bus.op_i      = 3'd7;
      bus.opdata1_i = 32'd1000;
      bus.opdata2_i = 32'd3;
      bus.start_i   = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      #2;
      rst         = 1'b1;
      bus.start_i = 1'b0;
      #1;
      check_output("arst_ready", {63'd0, bus.ready_o}, 64'd0);
      check_output("arst_busy", {63'd0, bus.busy_o}, 64'd0);
      check_output("arst_result", bus.result_o, 64'd0);
      check_output("arst_stall", {63'd0, bus.stallreq_o}, 64'd0);
      tick();
      rst       = 1'b0;
      saw_ready = 1'b0;
      cyc       = 0;
      while (cyc < 40) begin
         tick();
         cyc++;
         if (bus.ready_o === 1'b1) saw_ready = 1'b1;
      end
      check_output("arst_no_ready", {63'd0, saw_ready}, 64'd0);
      apply_stimulus("multu_after_rst", 3'd1, 32'd7, 32'd6, 32'd0, 32'd0,
                     2, 64'd42);

      apply_stimulus("divu_zero", 3'd7, 32'd5, 32'd0, 32'd0, 32'd0,
                     1, 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
